// File: rtl/link_pkg.sv
// Shared types and constants for the BL/RET link-stack controller.
package link_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PUSH,
      ST_CALL_COMMIT,
      ST_RET_COMMIT,
      ST_POP
   } link_state_t;

   localparam logic [31:0] WORD_BYTES = 32'd4;

   // Register-map indices of the special registers this block writes.
   localparam int unsigned REG_SP = 4;
   localparam int unsigned REG_LR = 5;
   localparam int unsigned REG_PC = 6;

endpackage

// File: rtl/link_stack_ctrl_if.sv
// Decoder request, special-register-file and data-memory channels of the
// link-stack controller. The controller owns the master side: it masters
// the register-file write ports and the memory bus.
interface link_stack_ctrl_if;

   logic        op_valid;
   logic        op_call;
   logic        op_ret;
   logic [31:0] op_target;
   logic        op_ready;

   logic [31:0] re_pc;
   logic [31:0] re_lr;
   logic [31:0] re_sp;
   logic        wr_pc;
   logic        wr_lr;
   logic        wr_sp;
   logic [31:0] wr_pc_data;
   logic [31:0] wr_lr_data;
   logic [31:0] wr_sp_data;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      input  op_valid, op_call, op_ret, op_target,
      input  re_pc, re_lr, re_sp,
      input  mem_ack, mem_rdata,
      output op_ready,
      output wr_pc, wr_lr, wr_sp, wr_pc_data, wr_lr_data, wr_sp_data,
      output mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output op_valid, op_call, op_ret, op_target,
      output re_pc, re_lr, re_sp,
      output mem_ack, mem_rdata,
      input  op_ready,
      input  wr_pc, wr_lr, wr_sp, wr_pc_data, wr_lr_data, wr_sp_data,
      input  mem_req, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/link_stack_ctrl.sv
// BL/RET sequencer: writes PC/LR/SP in the special-register file, spilling
// LR to a descending data-memory stack on nested calls and refilling it on
// return.
//
// state          | meaning
// ---------------+---------------------------------------------------------
// ST_IDLE        | op_ready high, waiting for a decoder request
// ST_PUSH        | spill LR to [SP-4]; SP<-SP-4 in the ack cycle
// ST_CALL_COMMIT | PC<-target, LR<-return address, depth+1
// ST_RET_COMMIT  | PC<-LR, depth-1; refill needed if frames remain
// ST_POP         | read [SP]; LR<-data, SP<-SP+4 in the ack cycle
module link_stack_ctrl
   import link_pkg::*;
#(
   parameter int MAX_DEPTH = 16,
   parameter int DEPTH_W   = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   link_stack_ctrl_if.master   bus,
   output logic [DEPTH_W-1:0]  depth,
   output logic                fault
);

   localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);
   localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

   link_state_t        state_q;
   logic [DEPTH_W-1:0] depth_q;
   logic [31:0]        tgt_q;
   logic [31:0]        pc_q;
   logic               fault_q;
   logic               wr_pc_q;
   logic [31:0]        wr_pc_data_q;
   logic               wr_lr_q;
   logic [31:0]        wr_lr_data_q;
   logic               mem_req_q;
   logic               mem_we_q;
   logic [31:0]        mem_addr_q;
   logic [31:0]        mem_wdata_q;

   logic               push_ack;
   logic               pop_ack;
   logic               bad_req;

   assign bad_req = (bus.op_call == bus.op_ret)
                 || (bus.op_call && depth_q == DEPTH_MAX)
                 || (bus.op_ret  && depth_q == '0);

   // FSM, depth counter, capture registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         depth_q      <= '0;
         tgt_q        <= '0;
         pc_q         <= '0;
         fault_q      <= 1'b0;
         wr_pc_q      <= 1'b0;
         wr_pc_data_q <= '0;
         wr_lr_q      <= 1'b0;
         wr_lr_data_q <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         fault_q      <= 1'b0;
         wr_pc_q      <= 1'b0;
         wr_pc_data_q <= '0;
         wr_lr_q      <= 1'b0;
         wr_lr_data_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (bus.op_valid) begin
                  tgt_q <= bus.op_target;
                  pc_q  <= bus.re_pc;
                  if (bad_req) begin
                     fault_q <= 1'b1;
                  end else if (bus.op_call && depth_q == '0) begin
                     state_q      <= ST_CALL_COMMIT;
                     wr_pc_q      <= 1'b1;
                     wr_pc_data_q <= bus.op_target;
                     wr_lr_q      <= 1'b1;
                     wr_lr_data_q <= bus.re_pc + WORD_BYTES;
                  end else if (bus.op_call) begin
                     // SP address is also the new SP value written on ack.
                     state_q     <= ST_PUSH;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= 1'b1;
                     mem_addr_q  <= bus.re_sp - WORD_BYTES;
                     mem_wdata_q <= bus.re_lr;
                  end else begin
                     state_q      <= ST_RET_COMMIT;
                     wr_pc_q      <= 1'b1;
                     wr_pc_data_q <= bus.re_lr;
                  end
               end
            end
            ST_PUSH: begin
               if (bus.mem_ack) begin
                  state_q      <= ST_CALL_COMMIT;
                  mem_req_q    <= 1'b0;
                  mem_we_q     <= 1'b0;
                  mem_addr_q   <= '0;
                  mem_wdata_q  <= '0;
                  wr_pc_q      <= 1'b1;
                  wr_pc_data_q <= tgt_q;
                  wr_lr_q      <= 1'b1;
                  wr_lr_data_q <= pc_q + WORD_BYTES;
               end
            end
            ST_CALL_COMMIT: begin
               depth_q <= depth_q + DEPTH_ONE;
               state_q <= ST_IDLE;
            end
            ST_RET_COMMIT: begin
               depth_q <= depth_q - DEPTH_ONE;
               if (depth_q > DEPTH_ONE) begin
                  state_q     <= ST_POP;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= bus.re_sp;
                  mem_wdata_q <= '0;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_POP: begin
               if (bus.mem_ack) begin
                  state_q    <= ST_IDLE;
                  mem_req_q  <= 1'b0;
                  mem_addr_q <= '0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Ack-cycle strobes: the memory completion is only known in that cycle.
   always_comb begin
      push_ack = (state_q == ST_PUSH) && mem_req_q && bus.mem_ack;
      pop_ack  = (state_q == ST_POP)  && mem_req_q && bus.mem_ack;
   end

   assign bus.op_ready   = (state_q == ST_IDLE);
   assign bus.wr_pc      = wr_pc_q;
   assign bus.wr_pc_data = wr_pc_data_q;
   assign bus.wr_lr      = wr_lr_q | pop_ack;
   assign bus.wr_lr_data = pop_ack ? bus.mem_rdata : wr_lr_data_q;
   assign bus.wr_sp      = push_ack | pop_ack;
   assign bus.wr_sp_data = push_ack ? mem_addr_q
                         : pop_ack  ? mem_addr_q + WORD_BYTES
                         : '0;
   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign depth          = depth_q;
   assign fault          = fault_q;

endmodule

// File: doc/link_stack_ctrl.md
# link_stack_ctrl

Multi-cycle controller for BL/RET in the Single Cycle Computer. It sits directly upstream of the special-register file and drives its SP, LR and PC write channels. For nested calls it spills the current LR to a data-memory stack, and on return it refills LR from that stack. The instruction decoder hands it one call/return request at a time and stalls on `op_ready`.

## Interface
- `MAX_DEPTH`, 16: maximum live call depth, including the frame held in LR.
- `DEPTH_W`, 5: width of `depth`; must satisfy 2^DEPTH_W > MAX_DEPTH.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `op_valid`  in  1  decoder request.
- `op_call`  in  1  request is BL.
- `op_ret`  in  1  request is RET.
- `op_target`  in  32  branch target for BL.
- `op_ready`  out  1  high exactly in IDLE.
- `re_pc`, `re_lr`, `re_sp`  in  32 each  current PC/LR/SP from the register file.
- `wr_pc`, `wr_lr`, `wr_sp`  out  1 each  one-cycle write strobes.
- `wr_pc_data`, `wr_lr_data`, `wr_sp_data`  out  32 each  write data.
- `mem_req`, `mem_we`  out  1 each  memory request and write-select.
- `mem_addr`, `mem_wdata`  out  32 each  memory byte address and write data.
- `mem_ack`  in  1  memory completes the request this cycle.
- `mem_rdata`  in  32  read data, valid with `mem_ack`.
- `depth`  out  DEPTH_W  live frame count.
- `fault`  out  1  one-cycle pulse on an illegal or overflowing request.

## Operation
- States: IDLE, PUSH, CALL_COMMIT, RET_COMMIT, POP.
- **Accept.** A request is accepted when `op_valid && op_ready`.
  - On accept, capture `op_target` into `tgt_q` and `re_pc` into `pc_q`.
- **Fault cases.** Each sets `fault` next cycle, performs no writes and stays in IDLE:
  - `op_call && op_ret` both high.
  - Both low.
  - CALL with `depth == MAX_DEPTH`.
  - RET with `depth == 0`.
- **CALL, depth 0:** go to CALL_COMMIT.
- **CALL, depth > 0:** go to PUSH.
  - PUSH holds `mem_req=1`, `mem_we=1`, `mem_addr=re_sp-4`, `mem_wdata=re_lr` until `mem_ack`.
  - In the ack cycle, pulse `wr_sp` with `re_sp-4`, then go to CALL_COMMIT.
- **CALL_COMMIT:**
  - Pulse `wr_pc` with `tgt_q` and `wr_lr` with `pc_q+4`.
  - `depth` increments; return to IDLE.
- **RET:** go to RET_COMMIT.
  - RET_COMMIT pulses `wr_pc` with `re_lr`; `depth` decrements.
  - If the new depth > 0, go to POP; otherwise go to IDLE.
- **POP:**
  - Hold `mem_req=1`, `mem_we=0`, `mem_addr=re_sp` until `mem_ack`.
  - In the ack cycle, pulse `wr_lr` with `mem_rdata` and `wr_sp` with `re_sp+4`, then go to IDLE.
- **Defaults.** All address arithmetic is modulo 2^32. Outputs not listed for a state are 0.
- **Memory contract.** `mem_*` request outputs are held stable while `mem_req=1 && !mem_ack`.

## Timing
- **Reset.** IDLE, `depth=0`, `fault=0`, and every strobe, `mem_req`/`mem_we`/`mem_addr`/`mem_wdata` and write-data output at 0. `op_ready` is 1.
- **Reset mid-operation.** Asserting `rst_n` low in PUSH or POP drops `mem_req` immediately (asynchronously). No further writes are issued.
- **CALL at depth 0.** Accept at cycle T; writes in T+1; `op_ready` is 1 again at T+2.
- **CALL with spill.** Accept at T; PUSH from T+1; ack at cycle A, with the `wr_sp` pulse in A; CALL_COMMIT in A+1; IDLE at A+2.
  - A one-cycle ack (ack in T+1) gives a 3-cycle turnaround.
- **RET.** Accept at T; `wr_pc` in T+1.
  - If POP is needed, `mem_req` rises at T+2; with ack at A, IDLE at A+1.
- **Register-file visibility.** The register file updates on the edge ending a strobe cycle, so `re_*` reflect the new value one cycle later. Each state reads `re_*` only after the previous write has landed.
- **Fault.** `fault` is high in the cycle after the offending accept.
- **Ack outside a request.** `mem_ack` while `mem_req=0` is ignored.

## Structure
- Shared package `link_pkg` holds:
  - the state enum `link_state_t`;
  - `WORD_BYTES = 4`;
  - the SP/LR/PC register indices 4/5/6 for consistency with the register map.
- No sub-module: the FSM, depth counter and capture registers form one block.

## Test plan
1. **Reset defaults.** Reset with `re_sp=0x1000` → `op_ready=1`, `depth=0`, no strobes, `mem_req=0`.
2. **Single BL.** BL `target=0x200` with `re_pc=0x40`, depth 0 → next cycle `wr_pc` with `0x200` and `wr_lr` with `0x44`; `depth=1`; `mem_req` stays 0.
3. **Spilled BL.** BL at depth 1 with `re_lr=0x44`, `re_sp=0x1000`, `mem_ack` delayed 3 cycles → `mem_addr=0xFFC` and `mem_wdata=0x44` held stable; `wr_sp` with `0xFFC` in the ack cycle; commit next cycle; `depth=2`.
4. **RET with refill.** RET at depth 2 with `re_lr=0x208`, `re_sp=0xFFC`, `mem_rdata=0x44` → `wr_pc` with `0x208`; then read at `0xFFC`; `wr_lr` with `0x44` and `wr_sp` with `0x1000`; `depth=1`.
5. **Fault cases.** Each leaves state and `depth` unchanged and pulses `fault` once:
   - RET at depth 0;
   - BL at depth 16;
   - `op_call` and `op_ret` both high.
6. **Reset mid-PUSH.** `rst_n` low during PUSH → `mem_req` falls without a clock edge; after release, `depth=0` and IDLE.
